// File: rtl/issue_pkg.sv
// Shared constants and types for the functional-unit issue stage.
package issue_pkg;

    localparam int NUM_FU   = 3;
    localparam int FU_ALU0  = 0;
    localparam int FU_ALU1  = 1;
    localparam int FU_LS    = 2;

    localparam int DEF_ALU_LAT = 1;
    localparam int DEF_LS_LAT  = 3;

    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_EXEC = 1'b1
    } fu_state_e;

endpackage

// File: rtl/fu_slot.sv
// One functional-unit slot: IDLE/EXEC state, latency down-counter and the
// operand/destination registers that stay frozen until writeback is granted.
module fu_slot
    import issue_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        grant,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [3:0]  ctrl_in,
    input  logic [5:0]  prd_in,
    input  logic [5:0]  rob_in,
    input  logic        rw_in,
    output logic        idle,
    output logic        done,
    output logic        start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [3:0]  ctrl,
    output logic [5:0]  prd,
    output logic [5:0]  rob,
    output logic        regwrite
);

    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    fu_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [5:0]  prd_q, prd_d;
    logic [5:0]  rob_q, rob_d;
    logic        rw_q, rw_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FU_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            ctrl_q  <= '0;
            prd_q   <= '0;
            rob_q   <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            ctrl_q  <= ctrl_d;
            prd_q   <= prd_d;
            rob_q   <= rob_d;
            rw_q    <= rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        ctrl_d  = ctrl_q;
        prd_d   = prd_q;
        rob_d   = rob_q;
        rw_d    = rw_q;
        case (state_q)
            FU_IDLE: begin
                if (accept) begin
                    state_d = FU_EXEC;
                    cnt_d   = CNT_INIT;
                    start_d = 1'b1;
                    op_a_d  = a_in;
                    op_b_d  = b_in;
                    ctrl_d  = ctrl_in;
                    prd_d   = prd_in;
                    rob_d   = rob_in;
                    rw_d    = rw_in;
                end
            end
            FU_EXEC: begin
                // A done slot waits here with its outputs frozen until granted.
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (grant) begin
                    state_d = FU_IDLE;
                end
            end
            default: state_d = FU_IDLE;
        endcase
    end

    always_comb begin
        idle     = (state_q == FU_IDLE);
        done     = (state_q == FU_EXEC) && (cnt_q == 3'd0);
        start    = start_q;
        op_a     = op_a_q;
        op_b     = op_b_q;
        ctrl     = ctrl_q;
        prd      = prd_q;
        rob      = rob_q;
        regwrite = rw_q;
    end

endmodule

// File: rtl/fu_issue_unit.sv
// Issue stage feeding two ALU slots and one load/store slot, with round-robin
// ALU selection and fixed-priority writeback. Optional ISSUE_STALL_CNT_EN adds stall_cnt.
module fu_issue_unit
    import issue_pkg::*;
#(
    parameter int ALU_LAT = DEF_ALU_LAT,
    parameter int LS_LAT  = DEF_LS_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_ctrl,
    input  logic [5:0]  in_prd,
    input  logic [5:0]  in_rob,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic        in_alusrc,
    input  logic        in_ls,
    input  logic        in_regwrite,
    output logic [2:0]  fu_start,
    output logic [95:0] fu_op_a,
    output logic [95:0] fu_op_b,
    output logic [11:0] fu_ctrl,
    output logic        wb_valid,
    output logic [5:0]  wb_prd,
    output logic [5:0]  wb_rob,
    output logic        wb_regwrite
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    logic        rr_q, rr_d;
    logic [2:0]  fu_idle, fu_done, fu_grant, fu_accept;
    logic [31:0] slot_op_a [NUM_FU];
    logic [31:0] slot_op_b [NUM_FU];
    logic [3:0]  slot_ctrl [NUM_FU];
    logic [5:0]  slot_prd  [NUM_FU];
    logic [5:0]  slot_rob  [NUM_FU];
    logic [2:0]  slot_rw;
    logic        is_nop, alu_sel, target_free, take;
    logic [31:0] op_b_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

    always_comb begin
        is_nop      = (in_alu_ctrl == 4'd0);
        alu_sel     = fu_idle[rr_q] ? rr_q : ~rr_q;
        target_free = in_ls ? fu_idle[FU_LS] : (fu_idle[FU_ALU0] | fu_idle[FU_ALU1]);
        in_ready    = !reset && (is_nop || target_free);
        // A no-op is consumed here and never reaches a slot or the pointer.
        take        = in_valid && in_ready && !is_nop;
        op_b_sel    = in_alusrc ? in_imm : in_rs2_val;
        fu_accept   = '0;
        rr_d        = rr_q;
        if (take) begin
            if (in_ls) begin
                fu_accept[FU_LS] = 1'b1;
            end else begin
                if (alu_sel) fu_accept[FU_ALU1] = 1'b1;
                else         fu_accept[FU_ALU0] = 1'b1;
                rr_d = ~alu_sel;
            end
        end
    end

    always_comb begin
        fu_grant = '0;
        if      (fu_done[FU_LS])   fu_grant[FU_LS]   = 1'b1;
        else if (fu_done[FU_ALU0]) fu_grant[FU_ALU0] = 1'b1;
        else if (fu_done[FU_ALU1]) fu_grant[FU_ALU1] = 1'b1;
        wb_valid    = |fu_done;
        wb_prd      = '0;
        wb_rob      = '0;
        wb_regwrite = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (fu_grant[k]) begin
                wb_prd      = slot_prd[k];
                wb_rob      = slot_rob[k];
                wb_regwrite = slot_rw[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_slot
        fu_slot #(
            .LAT((k == FU_LS) ? LS_LAT : ALU_LAT)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .accept   (fu_accept[k]),
            .grant    (fu_grant[k]),
            .a_in     (in_rs1_val),
            .b_in     (op_b_sel),
            .ctrl_in  (in_alu_ctrl),
            .prd_in   (in_prd),
            .rob_in   (in_rob),
            .rw_in    (in_regwrite),
            .idle     (fu_idle[k]),
            .done     (fu_done[k]),
            .start    (fu_start[k]),
            .op_a     (slot_op_a[k]),
            .op_b     (slot_op_b[k]),
            .ctrl     (slot_ctrl[k]),
            .prd      (slot_prd[k]),
            .rob      (slot_rob[k]),
            .regwrite (slot_rw[k])
        );
        assign fu_op_a[32*k +: 32] = slot_op_a[k];
        assign fu_op_b[32*k +: 32] = slot_op_b[k];
        assign fu_ctrl[4*k +: 4]   = slot_ctrl[k];
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fu_issue_unit.sv
// Randomized bench for fu_issue_unit: a timing-level reference model predicts
// acceptance, start pulses and writebacks; a monitor checks writebacks from a queue.
module tb_fu_issue_unit;

    localparam int ALU_LAT = 1;
    localparam int LS_LAT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_ctrl;
    logic [5:0]  in_prd, in_rob;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_alusrc, in_ls, in_regwrite;
    logic [2:0]  fu_start;
    logic [95:0] fu_op_a, fu_op_b;
    logic [11:0] fu_ctrl;
    logic        wb_valid;
    logic [5:0]  wb_prd, wb_rob;
    logic        wb_regwrite;
`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] m_stall;
`endif

    always #5 clk = ~clk;

    fu_issue_unit #(.ALU_LAT(ALU_LAT), .LS_LAT(LS_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_ctrl (in_alu_ctrl),
        .in_prd      (in_prd),
        .in_rob      (in_rob),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_imm      (in_imm),
        .in_alusrc   (in_alusrc),
        .in_ls       (in_ls),
        .in_regwrite (in_regwrite),
        .fu_start    (fu_start),
        .fu_op_a     (fu_op_a),
        .fu_op_b     (fu_op_b),
        .fu_ctrl     (fu_ctrl),
        .wb_valid    (wb_valid),
        .wb_prd      (wb_prd),
        .wb_rob      (wb_rob),
        .wb_regwrite (wb_regwrite)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [5:0] prd;
        logic [5:0] rob;
        logic       rw;
    } wb_rec_t;

    wb_rec_t wb_q[$];

    // Reference model: each unit is either free or holds one op that becomes
    // eligible for writeback at a known cycle; writeback goes LS, ALU0, ALU1.
    bit          m_busy [3];
    int          m_elig [3];
    int          m_acc  [3];
    logic [31:0] m_a    [3];
    logic [31:0] m_b    [3];
    logic [3:0]  m_c    [3];
    logic [5:0]  m_prd  [3];
    logic [5:0]  m_rob  [3];
    logic        m_rw   [3];
    int          m_rr;
    int          prio   [3] = '{2, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) m_busy[k] = 1'b0;
        m_rr = 0;
        wb_q.delete();
`ifdef ISSUE_STALL_CNT_EN
        m_stall = 16'd0;
`endif
    endtask

    task automatic step(input logic v, input logic [3:0] ctrl, input logic ls,
                        input logic alusrc, input logic rw, input logic [5:0] prd,
                        input logic [5:0] rob, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
        logic exp_ready;
        logic take;
        int   tgt;
        int   gnt;
        in_valid    = v;
        in_alu_ctrl = ctrl;
        in_ls       = ls;
        in_alusrc   = alusrc;
        in_regwrite = rw;
        in_prd      = prd;
        in_rob      = rob;
        in_rs1_val  = rs1;
        in_rs2_val  = rs2;
        in_imm      = imm;
        #1;
        exp_ready = (ctrl == 4'd0) || (ls ? !m_busy[2] : (!m_busy[0] || !m_busy[1]));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        for (int k = 0; k < 3; k++) begin
            chk("fu_start", 32'(fu_start[k]), 32'(m_busy[k] && (m_acc[k] == cyc)));
            if (m_busy[k]) begin
                chk("fu_op_a", fu_op_a[32*k +: 32], m_a[k]);
                chk("fu_op_b", fu_op_b[32*k +: 32], m_b[k]);
                chk("fu_ctrl", 32'(fu_ctrl[4*k +: 4]), 32'(m_c[k]));
            end
        end
        gnt = -1;
        for (int i = 0; i < 3; i++) begin
            if (gnt < 0 && m_busy[prio[i]] && cyc >= m_elig[prio[i]]) gnt = prio[i];
        end
        if (gnt >= 0) wb_q.push_back('{cyc, m_prd[gnt], m_rob[gnt], m_rw[gnt]});
        take = v && exp_ready && (ctrl != 4'd0);
        tgt  = -1;
        if (take) begin
            if (ls) begin
                tgt = 2;
            end else begin
                tgt  = !m_busy[m_rr] ? m_rr : 1 - m_rr;
                m_rr = 1 - tgt;
            end
        end
`ifdef ISSUE_STALL_CNT_EN
        if (v && !exp_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
        @(posedge clk);
        #1;
        if (gnt >= 0) m_busy[gnt] = 1'b0;
        if (tgt >= 0) begin
            m_busy[tgt] = 1'b1;
            m_acc[tgt]  = cyc;
            m_elig[tgt] = cyc + ((tgt == 2) ? LS_LAT : ALU_LAT) - 1;
            m_a[tgt]    = rs1;
            m_b[tgt]    = alusrc ? imm : rs2;
            m_c[tgt]    = ctrl;
            m_prd[tgt]  = prd;
            m_rob[tgt]  = rob;
            m_rw[tgt]   = rw;
        end
`ifdef ISSUE_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_alu_ctrl = 4'd3;
        in_ls       = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_fu_start", 32'(fu_start), 32'd0);
            chk("rst_op_zero", 32'(|{fu_op_a, fu_op_b, fu_ctrl}), 32'd0);
            @(posedge clk);
            #1;
        end
        model_clear();
        in_valid = 1'b0;
        reset    = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        wb_rec_t r;
        if (reset) begin
            chk("wb_valid_in_reset", 32'(wb_valid), 32'd0);
        end else if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                r = wb_q.pop_front();
                chk("wb_cycle", cyc, r.stamp);
                chk("wb_prd", 32'(wb_prd), 32'(r.prd));
                chk("wb_rob", 32'(wb_rob), 32'(r.rob));
                chk("wb_regwrite", 32'(wb_regwrite), 32'(r.rw));
            end
        end else if (wb_q.size() != 0 && wb_q[0].stamp <= cyc) begin
            chk("wb_missing", 32'(wb_valid), 32'd1);
            void'(wb_q.pop_front());
        end
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_alu_ctrl = '0;
        in_prd      = '0;
        in_rob      = '0;
        in_rs1_val  = '0;
        in_rs2_val  = '0;
        in_imm      = '0;
        in_alusrc   = 1'b0;
        in_ls       = 1'b0;
        in_regwrite = 1'b0;
        model_clear();
        do_reset(3);

        // ALU op with immediate operand, single-cycle latency.
        step(1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 6'd9, 6'd3, 32'd5, 32'd99, 32'd7);
        chk("dir_start0", 32'(fu_start), 32'd1);
        chk("dir_op_b", fu_op_b[31:0], 32'd7);
        chk("dir_wb_prd", 32'(wb_prd), 32'd9);
        idle(2);

        // Back-to-back ALU ops, then LS and ALU finishing together.
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 6'd1, 6'd11, 32'd10, 32'd20, 32'd0);
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 6'd2, 6'd12, 32'd30, 32'd40, 32'd0);
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 6'd3, 6'd13, 32'd50, 32'd60, 32'd0);
        idle(2);
        step(1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 6'd4, 6'd14, 32'd70, 32'd0, 32'd8);
        step(1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 6'd5, 6'd15, 32'd71, 32'd0, 32'd9);
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 6'd6, 6'd16, 32'd72, 32'd73, 32'd0);
        idle(4);

        // No-op is accepted and discarded even while LS is busy.
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd7, 6'd17, 32'd1, 32'd2, 32'd3);
        step(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 6'd8, 6'd18, 32'd1, 32'd2, 32'd3);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3, 0) != 0,
                 ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1)),
                 $urandom_range(2, 0) == 0,
                 1'($urandom), 1'($urandom),
                 6'($urandom), 6'($urandom),
                 $urandom, $urandom, $urandom);
        end
        idle(6);

        // Reset while the LS op has one cycle left: it must never write back.
        step(1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 6'd20, 6'd21, 32'd5, 32'd6, 32'd0);
        idle(1);
        do_reset(2);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 6'd22, 6'd23, 32'd7, 32'd8, 32'd0);
        chk("post_rst_fu0", 32'(fu_start), 32'd1);
        idle(4);

`ifdef ISSUE_STALL_CNT_EN
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd30, 6'd31, 32'd1, 32'd2, 32'd3);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 16'hFFFE;
        for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd32, 6'd33, 32'd1, 32'd2, 32'd3);
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        idle(4);
`endif

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(1, 0) == 1, 4'($urandom_range(15, 1)),
                 $urandom_range(3, 0) == 0, 1'($urandom), 1'($urandom),
                 6'($urandom), 6'($urandom), $urandom, $urandom, $urandom);
        end
        idle(8);
        chk("queue_drained", 32'(wb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
